// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer slice.
package alarm_pkg;

  typedef enum logic [1:0] {
    StDisarmed,
    StArmed,
    StRinging,
    StSnooze
  } alarm_state_e;

  localparam int unsigned DefaultRingSecs   = 60;
  localparam int unsigned DefaultSnoozeSecs = 540;
  localparam int unsigned HourW             = 4;
  localparam int unsigned MinW              = 6;

  // Counter width large enough to hold the larger of the two reload values.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// Button, time/alarm value and alarm status signals of the alarm sequencer.
interface alarm_sequencer_if;
  import alarm_pkg::*;

  logic             sec_tick;
  logic             alarm_en;
  logic             set_alarm;
  logic             set_time;
  logic             hours_btn;
  logic             mins_btn;
  logic             stop_btn;
  logic             snooze_btn;
  logic [HourW-1:0] time_hours;
  logic [MinW-1:0]  time_mins;
  logic             time_am_pm;
  logic [HourW-1:0] alarm_hours;
  logic [MinW-1:0]  alarm_mins;
  logic             alarm_am_pm;
  logic             alarm_hours_inc;
  logic             alarm_mins_inc;
  logic             time_hours_inc;
  logic             time_mins_inc;
  logic             buzzer;
  logic             ringing;
  logic             snoozing;

  modport master (
    output sec_tick, alarm_en, set_alarm, set_time, hours_btn, mins_btn, stop_btn, snooze_btn,
    output time_hours, time_mins, time_am_pm, alarm_hours, alarm_mins, alarm_am_pm,
    input  alarm_hours_inc, alarm_mins_inc, time_hours_inc, time_mins_inc,
    input  buzzer, ringing, snoozing
  );

  modport slave (
    input  sec_tick, alarm_en, set_alarm, set_time, hours_btn, mins_btn, stop_btn, snooze_btn,
    input  time_hours, time_mins, time_am_pm, alarm_hours, alarm_mins, alarm_am_pm,
    output alarm_hours_inc, alarm_mins_inc, time_hours_inc, time_mins_inc,
    output buzzer, ringing, snoozing
  );

endinterface

// File: rtl/alarm_tick_counter.sv
// Loadable seconds down-counter; expire_o pulses on the tick that consumes the last second.
module alarm_tick_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  input  logic             tick_i,
  output logic             expire_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // A tick coinciding with a load is swallowed; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (en_i && tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign expire_o = en_i & tick_i & ~load_i & (cnt_q == Width'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm controller: steers set buttons, detects alarm match, sequences ring/snooze/stop.
// Optional BEEP_PATTERN_EN gates the buzzer 1 s on / 1 s off while ringing.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int unsigned RingSecs   = DefaultRingSecs,
  parameter int unsigned SnoozeSecs = DefaultSnoozeSecs
) (
  input logic               clk,
  input logic               reset,
  alarm_sequencer_if.slave  bus
);

  localparam int unsigned   CntW       = cnt_width(RingSecs, SnoozeSecs);
  localparam logic [CntW-1:0] RingLoad = CntW'(RingSecs);
  localparam logic [CntW-1:0] SnzLoad  = CntW'(SnoozeSecs);

  alarm_state_e state_q, state_d;
  logic match, match_q, trigger;
  logic ring_load, snz_load, ring_expire, snz_expire;
  logic alarm_hours_inc_q, alarm_mins_inc_q, time_hours_inc_q, time_mins_inc_q;
  logic buzzer_q, buzzer_d, ringing_q, snoozing_q;

  assign match   = (bus.time_hours == bus.alarm_hours) && (bus.time_mins == bus.alarm_mins) &&
                   (bus.time_am_pm == bus.alarm_am_pm);
  // Edge-only trigger: stopping inside the matching minute must not re-ring.
  assign trigger = match & ~match_q & ~bus.set_alarm & ~bus.set_time;

  always_comb begin
    state_d   = state_q;
    ring_load = 1'b0;
    snz_load  = 1'b0;
    if (!bus.alarm_en) begin
      state_d = StDisarmed;
    end else begin
      unique case (state_q)
        StDisarmed: state_d = StArmed;
        StArmed: begin
          if (trigger) begin
            state_d   = StRinging;
            ring_load = 1'b1;
          end
        end
        StRinging: begin
          if (bus.stop_btn) begin
            state_d = StArmed;
          end else if (bus.snooze_btn) begin
            state_d  = StSnooze;
            snz_load = 1'b1;
          end else if (ring_expire) begin
            state_d = StArmed;
          end
        end
        StSnooze: begin
          if (bus.stop_btn) begin
            state_d = StArmed;
          end else if (snz_expire) begin
            state_d   = StRinging;
            ring_load = 1'b1;
          end
        end
        default: state_d = StDisarmed;
      endcase
    end
  end

  alarm_tick_counter #(
    .Width (CntW)
  ) u_ring_cnt (
    .clk      (clk),
    .reset    (reset),
    .en_i     (state_q == StRinging),
    .load_i   (ring_load),
    .value_i  (RingLoad),
    .tick_i   (bus.sec_tick),
    .expire_o (ring_expire)
  );

  alarm_tick_counter #(
    .Width (CntW)
  ) u_snz_cnt (
    .clk      (clk),
    .reset    (reset),
    .en_i     (state_q == StSnooze),
    .load_i   (snz_load),
    .value_i  (SnzLoad),
    .tick_i   (bus.sec_tick),
    .expire_o (snz_expire)
  );

`ifdef BEEP_PATTERN_EN
  logic beep_q, beep_d;

  always_comb begin
    beep_d = beep_q;
    if ((state_d == StRinging) && (state_q != StRinging)) begin
      beep_d = 1'b1;
    end else if ((state_q == StRinging) && bus.sec_tick) begin
      beep_d = ~beep_q;
    end
    buzzer_d = (state_d == StRinging) & beep_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beep_q <= 1'b0;
    end else begin
      beep_q <= beep_d;
    end
  end
`else
  assign buzzer_d = (state_d == StRinging);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= StDisarmed;
      match_q           <= 1'b0;
      alarm_hours_inc_q <= 1'b0;
      alarm_mins_inc_q  <= 1'b0;
      time_hours_inc_q  <= 1'b0;
      time_mins_inc_q   <= 1'b0;
      buzzer_q          <= 1'b0;
      ringing_q         <= 1'b0;
      snoozing_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      match_q           <= match;
      alarm_hours_inc_q <= bus.set_alarm & bus.hours_btn;
      alarm_mins_inc_q  <= bus.set_alarm & bus.mins_btn;
      time_hours_inc_q  <= ~bus.set_alarm & bus.set_time & bus.hours_btn;
      time_mins_inc_q   <= ~bus.set_alarm & bus.set_time & bus.mins_btn;
      buzzer_q          <= buzzer_d;
      ringing_q         <= (state_d == StRinging);
      snoozing_q        <= (state_d == StSnooze);
    end
  end

  assign bus.alarm_hours_inc = alarm_hours_inc_q;
  assign bus.alarm_mins_inc  = alarm_mins_inc_q;
  assign bus.time_hours_inc  = time_hours_inc_q;
  assign bus.time_mins_inc   = time_mins_inc_q;
  assign bus.buzzer          = buzzer_q;
  assign bus.ringing         = ringing_q;
  assign bus.snoozing        = snoozing_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with RingSecs=3, SnoozeSecs=4.
module tb_alarm_sequencer;

  logic clk;
  logic reset;
  int unsigned checks;
  int unsigned errors;

  alarm_sequencer_if bus_if ();

  alarm_sequencer #(
    .RingSecs   (3),
    .SnoozeSecs (4)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus_if.sec_tick = 1'b1;
    step();
    bus_if.sec_tick = 1'b0;
  endtask

  task automatic press_snooze();
    bus_if.snooze_btn = 1'b1;
    step();
    bus_if.snooze_btn = 1'b0;
  endtask

  task automatic press_stop();
    bus_if.stop_btn = 1'b1;
    step();
    bus_if.stop_btn = 1'b0;
  endtask

  // Leave the alarm minute and come back to create a fresh match edge.
  task automatic retrigger();
    bus_if.time_mins = 6'd31;
    step();
    bus_if.time_mins = 6'd30;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus_if.sec_tick    = 1'b0;
    bus_if.alarm_en    = 1'b0;
    bus_if.set_alarm   = 1'b0;
    bus_if.set_time    = 1'b0;
    bus_if.hours_btn   = 1'b0;
    bus_if.mins_btn    = 1'b0;
    bus_if.stop_btn    = 1'b0;
    bus_if.snooze_btn  = 1'b0;
    bus_if.time_hours  = 4'd6;
    bus_if.time_mins   = 6'd29;
    bus_if.time_am_pm  = 1'b0;
    bus_if.alarm_hours = 4'd6;
    bus_if.alarm_mins  = 6'd30;
    bus_if.alarm_am_pm = 1'b0;
    step();
    step();
    check_val("reset_outputs", {25'd0, bus_if.alarm_hours_inc, bus_if.alarm_mins_inc,
              bus_if.time_hours_inc, bus_if.time_mins_inc, bus_if.buzzer, bus_if.ringing,
              bus_if.snoozing}, 32'd0);
    reset = 1'b0;
    step();

    // Routing: alarm wins when both set modes are active
    bus_if.set_alarm = 1'b1;
    bus_if.set_time  = 1'b1;
    bus_if.hours_btn = 1'b1;
    step();
    bus_if.hours_btn = 1'b0;
    check_val("route_alarm_hours", {31'd0, bus_if.alarm_hours_inc}, 32'd1);
    check_val("route_no_time_hours", {31'd0, bus_if.time_hours_inc}, 32'd0);
    step();
    check_val("route_pulse_one_cycle", {31'd0, bus_if.alarm_hours_inc}, 32'd0);
    bus_if.set_alarm = 1'b0;
    bus_if.mins_btn  = 1'b1;
    step();
    bus_if.mins_btn = 1'b0;
    check_val("route_time_mins", {30'd0, bus_if.time_mins_inc, bus_if.alarm_mins_inc}, 32'd2);
    bus_if.set_time  = 1'b0;
    bus_if.hours_btn = 1'b1;
    bus_if.mins_btn  = 1'b1;
    step();
    bus_if.hours_btn = 1'b0;
    bus_if.mins_btn  = 1'b0;
    check_val("route_dropped", {28'd0, bus_if.alarm_hours_inc, bus_if.alarm_mins_inc,
              bus_if.time_hours_inc, bus_if.time_mins_inc}, 32'd0);

    // Arm, then 6:29 PM -> 6:30 PM must not ring an AM alarm
    bus_if.alarm_en   = 1'b1;
    bus_if.time_am_pm = 1'b1;
    step();
    bus_if.time_mins = 6'd30;
    step();
    step();
    check_val("pm_no_ring", {31'd0, bus_if.ringing}, 32'd0);

    // 6:29 AM -> 6:30 AM rings
    bus_if.time_am_pm = 1'b0;
    bus_if.time_mins  = 6'd29;
    step();
    bus_if.time_mins = 6'd30;
    step();
    check_val("trigger_ringing", {31'd0, bus_if.ringing}, 32'd1);
    check_val("trigger_buzzer", {31'd0, bus_if.buzzer}, 32'd1);

    // Auto-stop after exactly 3 ticks
    tick();
    check_val("ring_tick1", {31'd0, bus_if.ringing}, 32'd1);
`ifdef BEEP_PATTERN_EN
    check_val("beep_tick1", {31'd0, bus_if.buzzer}, 32'd0);
`else
    check_val("buzz_tick1", {31'd0, bus_if.buzzer}, 32'd1);
`endif
    tick();
    check_val("ring_tick2", {31'd0, bus_if.ringing}, 32'd1);
    check_val("buzz_tick2", {31'd0, bus_if.buzzer}, 32'd1);
    tick();
    check_val("ring_autostop", {30'd0, bus_if.ringing, bus_if.buzzer}, 32'd0);
    tick();
    step();
    check_val("no_rering", {31'd0, bus_if.ringing}, 32'd0);

    // Snooze: tick in the load cycle is not counted, SNOOZE_BTN ignored while snoozing
    retrigger();
    check_val("snz_pre_ring", {31'd0, bus_if.ringing}, 32'd1);
    bus_if.sec_tick = 1'b1;
    press_snooze();
    bus_if.sec_tick = 1'b0;
    check_val("snz_enter", {29'd0, bus_if.snoozing, bus_if.ringing, bus_if.buzzer}, 32'd4);
    tick();
    tick();
    check_val("snz_tick2", {31'd0, bus_if.snoozing}, 32'd1);
    press_snooze();
    tick();
    check_val("snz_tick3", {31'd0, bus_if.snoozing}, 32'd1);
    tick();
    check_val("snz_rering", {29'd0, bus_if.snoozing, bus_if.ringing, bus_if.buzzer}, 32'd3);
    tick();
    tick();
    check_val("ring_reloaded", {31'd0, bus_if.ringing}, 32'd1);
    bus_if.stop_btn = 1'b1;
    press_snooze();
    bus_if.stop_btn = 1'b0;
    check_val("stop_beats_snooze", {30'd0, bus_if.snoozing, bus_if.ringing}, 32'd0);

    // Stop cancels a snooze
    retrigger();
    press_snooze();
    check_val("snz_again", {31'd0, bus_if.snoozing}, 32'd1);
    press_stop();
    check_val("snz_cancel", {30'd0, bus_if.snoozing, bus_if.ringing}, 32'd0);

    // A set mode masks the match edge
    bus_if.time_mins = 6'd31;
    step();
    bus_if.set_time  = 1'b1;
    bus_if.time_mins = 6'd30;
    step();
    check_val("set_masks_trigger", {31'd0, bus_if.ringing}, 32'd0);
    bus_if.set_time = 1'b0;
    step();
    check_val("edge_consumed", {31'd0, bus_if.ringing}, 32'd0);

    // Disarm mid-ring and mid-snooze
    retrigger();
    bus_if.alarm_en = 1'b0;
    step();
    check_val("disarm_ring", {30'd0, bus_if.ringing, bus_if.buzzer}, 32'd0);
    bus_if.alarm_en = 1'b1;
    step();
    retrigger();
    press_snooze();
    bus_if.alarm_en = 1'b0;
    step();
    check_val("disarm_snooze", {31'd0, bus_if.snoozing}, 32'd0);
    bus_if.alarm_en = 1'b1;
    step();

    // Synchronous reset mid-ring
    retrigger();
    check_val("pre_reset_ring", {31'd0, bus_if.ringing}, 32'd1);
    reset = 1'b1;
    step();
    check_val("reset_mid_ring", {29'd0, bus_if.ringing, bus_if.buzzer, bus_if.snoozing}, 32'd0);
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
